// File: rtl/mux_serializer_pkg.sv
// rtl/mux_serializer_pkg.sv - shared types and helpers for the word serializer
//
// Purpose: holds the serializer state encoding, the list of supported word
// widths and the index-width helper shared by the top and the mux tree.
// Ports: none (package).
package mux_serializer_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,  // no word held
    ST_SHIFT = 1'b1   // bits of a word being emitted
  } state_t;

  localparam int NUM_LEGAL_WIDTHS = 4;
  localparam int LEGAL_WIDTHS [NUM_LEGAL_WIDTHS] = '{2, 4, 8, 16};

  // Number of index bits (and mux-tree levels) needed for a word width.
  function automatic int idx_width(input int width);
    return $clog2(width);
  endfunction

  function automatic bit width_legal(input int width);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < NUM_LEGAL_WIDTHS; i++) begin
      if (LEGAL_WIDTHS[i] == width) ok = 1'b1;
    end
    return ok;
  endfunction

endpackage

// File: rtl/mux_serializer_mux_tree.sv
// rtl/mux_serializer_mux_tree.sv - binary tree of 2:1 muxes selecting one word bit
//
// Purpose: picks data[sel] using log2(WIDTH) levels of 2:1 muxes; sel[0]
// steers the first (leaf-side) level, the MSB of sel steers the root.
// Ports:
//   data    - word being serialized
//   sel     - bit index
//   bit_out - selected bit
module mux_tree
  import mux_serializer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]         data,
  input  logic [$clog2(WIDTH)-1:0] sel,
  output logic                     bit_out
);

  localparam int LEVELS = idx_width(WIDTH);

  // Each level halves the candidate set; levels are separate signals so the
  // tree stays a clean acyclic combinational network.
  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    logic [(WIDTH >> l)-1:0]     d_in;
    logic [(WIDTH >> (l+1))-1:0] q;

    if (l == 0) begin : g_first
      assign d_in = data;
    end else begin : g_next
      assign d_in = g_lvl[l-1].q;
    end

    for (genvar i = 0; i < (WIDTH >> (l+1)); i++) begin : g_mux
      assign q[i] = sel[l] ? d_in[2*i+1] : d_in[2*i];
    end
  end

  assign bit_out = g_lvl[LEVELS-1].q[0];

endmodule

// File: rtl/mux_serializer.sv
// rtl/mux_serializer.sv - parallel-load, LSB-first word serializer
//
// Purpose: accepts a WIDTH-bit word with a valid/ready handshake and emits it
// one registered bit per enabled clock, supporting back-to-back words.
// Ports:
//   C          - clock, rising edge
//   CLR        - asynchronous active-high reset
//   CE         - clock enable; low holds all state
//   D          - parallel word, bit 0 sent first
//   LOAD_VALID - D holds a word offered for loading
//   LOAD_READY - word on D is accepted on this edge (combinational)
//   O          - registered serial bit
//   O_VALID    - O carries a valid bit
//   LAST       - O carries bit WIDTH-1 of the current word
module mux_serializer
  import mux_serializer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             C,
  input  logic             CLR,
  input  logic             CE,
  input  logic [WIDTH-1:0] D,
  input  logic             LOAD_VALID,
  output logic             LOAD_READY,
  output logic             O,
  output logic             O_VALID,
  output logic             LAST
);

  localparam int IW = idx_width(WIDTH);
  localparam logic [IW-1:0] IDX_LAST = IW'(WIDTH - 1);

  state_t           state;
  logic [IW-1:0]    index;
  logic [WIDTH-1:0] word;
  logic             sel_bit;
  logic             accept;

  // Ready while idle or while the final bit is on O, so the next word can
  // follow with no gap. Held low during CLR so nothing is accepted then.
  assign LOAD_READY = CE & ~CLR & ((state == ST_IDLE) | LAST);
  assign accept     = LOAD_VALID & LOAD_READY;

  mux_tree #(.WIDTH(WIDTH)) u_mux_tree (
    .data    (word),
    .sel     (index),
    .bit_out (sel_bit)
  );

  always_ff @(posedge C or posedge CLR) begin
    if (CLR) begin
      state   <= ST_IDLE;
      index   <= '0;
      word    <= '0;
      O       <= 1'b0;
      O_VALID <= 1'b0;
      LAST    <= 1'b0;
    end else if (CE) begin
      if (accept) begin
        // Bit 0 goes straight from D so it appears on the accept edge.
        state   <= ST_SHIFT;
        word    <= D;
        O       <= D[0];
        O_VALID <= 1'b1;
        LAST    <= 1'b0;
        index   <= IW'(1);
      end else if (state == ST_SHIFT) begin
        if (LAST) begin
          state   <= ST_IDLE;
          O_VALID <= 1'b0;
          LAST    <= 1'b0;
        end else begin
          O       <= sel_bit;
          O_VALID <= 1'b1;
          LAST    <= (index == IDX_LAST);
          // Stop at the top index instead of wrapping; the next accept
          // reloads it anyway.
          if (index != IDX_LAST) index <= index + IW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_mux_serializer.sv
// tb/tb_mux_serializer.sv - self-checking bench for mux_serializer (WIDTH 8, 2, 16)
module tb_mux_serializer;

  localparam int N = 3;
  localparam int WV [N] = '{8, 2, 16};

  logic        clk;
  logic        clr;
  logic        ce;
  logic [15:0] d_in  [N];
  logic        lv    [N];
  logic        rdy   [N];
  logic        o     [N];
  logic        ov    [N];
  logic        lst   [N];

  int checks;
  int failures;

  // Reference: pos = number of bits of the current word already shown on O
  // (0 = nothing held, WV = final bit showing).
  int          m_pos  [N];
  logic [15:0] m_word [N];
  logic        m_o    [N];

  mux_serializer #(.WIDTH(8)) dut8 (
    .C(clk), .CLR(clr), .CE(ce), .D(d_in[0][7:0]), .LOAD_VALID(lv[0]),
    .LOAD_READY(rdy[0]), .O(o[0]), .O_VALID(ov[0]), .LAST(lst[0])
  );
  mux_serializer #(.WIDTH(2)) dut2 (
    .C(clk), .CLR(clr), .CE(ce), .D(d_in[1][1:0]), .LOAD_VALID(lv[1]),
    .LOAD_READY(rdy[1]), .O(o[1]), .O_VALID(ov[1]), .LAST(lst[1])
  );
  mux_serializer #(.WIDTH(16)) dut16 (
    .C(clk), .CLR(clr), .CE(ce), .D(d_in[2]), .LOAD_VALID(lv[2]),
    .LOAD_READY(rdy[2]), .O(o[2]), .O_VALID(ov[2]), .LAST(lst[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit model_ready(input int k);
    return ce && !clr && (m_pos[k] == 0 || m_pos[k] == WV[k]);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      m_pos[k] = 0; m_word[k] = '0; m_o[k] = 1'b0;
    end
  endtask

  task automatic check_outputs();
    for (int k = 0; k < N; k++) begin
      check($sformatf("w%0d_o", WV[k]), 32'(o[k]), 32'(m_o[k]));
      check($sformatf("w%0d_ovalid", WV[k]), 32'(ov[k]), 32'(m_pos[k] > 0));
      check($sformatf("w%0d_last", WV[k]), 32'(lst[k]), 32'(m_pos[k] == WV[k]));
    end
  endtask

  // One clock: check readiness before the edge, advance the model with the
  // inputs that were stable across the edge, then check registered outputs.
  task automatic tick();
    bit r [N];
    #1;
    for (int k = 0; k < N; k++) begin
      r[k] = model_ready(k);
      check($sformatf("w%0d_ready", WV[k]), 32'(rdy[k]), 32'(r[k]));
    end
    @(posedge clk);
    for (int k = 0; k < N; k++) begin
      if (clr) begin
        m_pos[k] = 0; m_word[k] = '0; m_o[k] = 1'b0;
      end else if (ce) begin
        if (lv[k] && r[k]) begin
          m_word[k] = d_in[k] & ((17'd1 << WV[k]) - 17'd1);
          m_pos[k]  = 1;
          m_o[k]    = m_word[k][0];
        end else if (m_pos[k] == WV[k]) begin
          m_pos[k] = 0;
        end else if (m_pos[k] > 0) begin
          m_o[k]   = m_word[k][m_pos[k]];
          m_pos[k] = m_pos[k] + 1;
        end
      end
    end
    #1;
    check_outputs();
  endtask

  task automatic idle_inputs();
    for (int k = 0; k < N; k++) begin
      lv[k] = 1'b0; d_in[k] = 16'($urandom);
    end
  endtask

  initial begin
    logic [15:0] col [N];
    logic [15:0] v16;
    int          nlast;
    int          nvalid;

    checks = 0; failures = 0;
    clr = 1'b0; ce = 1'b0;
    idle_inputs();
    model_reset();

    // Reset state
    #1 clr = 1'b1;
    #1 check_outputs();
    for (int k = 0; k < N; k++) check("reset_ready", 32'(rdy[k]), 32'd0);
    tick();
    clr = 1'b0; ce = 1'b1;
    tick();

    // A5 on WIDTH 8, 2'b10 on WIDTH 2, 8001 on WIDTH 16 in parallel
    d_in[0] = 16'h00A5; d_in[1] = 16'h0002; d_in[2] = 16'h8001;
    for (int k = 0; k < N; k++) begin lv[k] = 1'b1; col[k] = '0; end
    nlast = 0;
    for (int t = 0; t < 17; t++) begin
      tick();
      for (int k = 0; k < N; k++) begin
        lv[k] = 1'b0; d_in[k] = 16'($urandom);
        if (t < WV[k]) begin
          col[k][t] = o[k];
          check($sformatf("w%0d_dir_last", WV[k]), 32'(lst[k]), 32'(t == WV[k]-1));
        end
        if (t == WV[k]) check($sformatf("w%0d_gap_valid", WV[k]), 32'(ov[k]), 32'd0);
      end
    end
    check("w8_a5_bits", 32'(col[0][7:0]), 32'h00A5);
    check("w2_10_bits", 32'(col[1][1:0]), 32'h2);
    check("w16_8001_bits", 32'(col[2]), 32'h8001);

    // Back-to-back 0F then F0 with LOAD_VALID held
    lv[0] = 1'b1; d_in[0] = 16'h000F;
    v16 = '0; nvalid = 0;
    for (int t = 0; t < 16; t++) begin
      tick();
      v16[t] = o[0];
      if (ov[0]) nvalid++;
      if (t == 0) d_in[0] = 16'h00F0;
      if (t == 8) lv[0] = 1'b0;
    end
    check("b2b_bits", 32'(v16), 32'hF00F);
    check("b2b_valid_count", 32'(nvalid), 32'd16);
    tick();

    // CE low for three cycles after bit 3 of 3C
    lv[0] = 1'b1; d_in[0] = 16'h003C;
    v16 = '0;
    for (int t = 0; t < 4; t++) begin
      tick(); lv[0] = 1'b0; v16[t] = o[0];
    end
    ce = 1'b0;
    for (int t = 0; t < 3; t++) begin
      lv[0] = 1'b1; d_in[0] = 16'($urandom);
      tick();
      check("ce_hold_o", 32'(o[0]), 32'd1);
      check("ce_hold_valid", 32'(ov[0]), 32'd1);
    end
    ce = 1'b1; lv[0] = 1'b0;
    for (int t = 4; t < 8; t++) begin
      tick(); v16[t] = o[0];
    end
    check("ce_resume_bits", 32'(v16[7:0]), 32'h003C);
    tick();

    // Asynchronous CLR after bit 2, LOAD_VALID offered during the clear
    lv[0] = 1'b1; d_in[0] = 16'h00FF;
    for (int t = 0; t < 3; t++) begin tick(); lv[0] = 1'b0; end
    clr = 1'b1;
    #1;
    model_reset();
    check("clr_async_o", 32'(o[0]), 32'd0);
    check("clr_async_valid", 32'(ov[0]), 32'd0);
    check("clr_async_last", 32'(lst[0]), 32'd0);
    check("clr_ready", 32'(rdy[0]), 32'd0);
    lv[0] = 1'b1;
    tick();
    clr = 1'b0; lv[0] = 1'b0;
    #1 check("clr_release_ready", 32'(rdy[0]), 32'd1);
    tick();

    // Randomized traffic, occasional enable drops and clears
    for (int t = 0; t < 500; t++) begin
      ce  = ($urandom_range(0, 7) != 0);
      clr = ($urandom_range(0, 59) == 0);
      for (int k = 0; k < N; k++) begin
        lv[k]   = ($urandom_range(0, 2) != 0);
        d_in[k] = 16'($urandom);
      end
      tick();
    end
    clr = 1'b0; ce = 1'b1;
    idle_inputs();
    for (int t = 0; t < 20; t++) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
